// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: op encoding, FSM states and flag bit positions.
package alu_pkg;

  typedef enum logic [2:0] {
    OP_AND = 3'b000,
    OP_OR  = 3'b001,
    OP_XOR = 3'b010,
    OP_NOT = 3'b011,
    OP_ADD = 3'b100,
    OP_SUB = 3'b101,
    OP_MUL = 3'b110,
    OP_NOR = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_MUL  = 2'd2
  } state_e;

  // Bit positions inside the {N,Z,C,V} flags word.
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

endpackage

// File: rtl/alu_logic_w.sv
// Combinational W-bit logic unit covering AND/OR/XOR/NOT/NOR.
module alu_logic_w
  import alu_pkg::*;
#(
  parameter int W = 8
) (
  input  logic [2:0]   op,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] y
);

  always_comb begin
    y = '0;
    case (op)
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_XOR:  y = a ^ b;
      OP_NOT:  y = ~a;
      OP_NOR:  y = ~(a | b);
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU: single-cycle logic/add/sub, W-cycle shift-add multiply, registered result and flags.
//
//   state   | meaning
//   --------+---------------------------------------------------------------
//   ST_IDLE | waiting for start; operands and first result/step captured on accept
//   ST_EXEC | one-cycle op: result already registered, busy and done high
//   ST_MUL  | shift-add multiply, one multiplier bit per cycle; done when cnt hits 1
module alu_seq
  import alu_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [2:0]   op,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] result,
  output logic [3:0]   flags
);

  localparam int CW = $clog2(W + 1);

  state_e         state, state_nxt;
  logic [CW-1:0]  cnt;
  logic           accept, mul_last;

  logic [W-1:0]   mcand;
  logic [2*W-1:0] prod, prod_step, step_in;
  logic [W-1:0]   step_mcand;
  logic [W:0]     step_sum;

  logic [W-1:0]   logic_y;
  logic [W:0]     sum, diff;
  logic [W-1:0]   exec_r;
  logic           exec_c, exec_v;

  logic           wr_res;
  logic [W-1:0]   res_nxt;
  logic           c_nxt, v_nxt;
  logic [3:0]     flg_nxt;

  alu_logic_w #(.W(W)) u_logic (
    .op (op),
    .a  (a),
    .b  (b),
    .y  (logic_y)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    accept    = 1'b0;
    mul_last  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = (op == OP_MUL) ? ST_MUL : ST_EXEC;
        end
      end
      ST_EXEC: begin
        busy      = 1'b1;
        done      = 1'b1;
        state_nxt = ST_IDLE;
      end
      ST_MUL: begin
        busy = 1'b1;
        if (cnt == CW'(1)) begin
          done      = 1'b1;
          state_nxt = ST_IDLE;
        end else begin
          mul_last = (cnt == CW'(2));
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Single-cycle ops are evaluated straight from the inputs on the accept edge,
  // so the registered result is already valid in the EXEC (done) cycle.
  always_comb begin
    sum    = {1'b0, a} + {1'b0, b};
    diff   = {1'b0, a} - {1'b0, b};
    exec_r = logic_y;
    exec_c = 1'b0;
    exec_v = 1'b0;
    case (op)
      OP_ADD: begin
        exec_r = sum[W-1:0];
        exec_c = sum[W];
        exec_v = (a[W-1] == b[W-1]) && (sum[W-1] != a[W-1]);
      end
      OP_SUB: begin
        exec_r = diff[W-1:0];
        exec_c = ~diff[W];
        exec_v = (a[W-1] != b[W-1]) && (diff[W-1] != a[W-1]);
      end
      default: ;
    endcase
  end

  // Multiplier bit 0 is consumed on the accept edge; the remaining W-1 bits in
  // ST_MUL while cnt runs W..2, leaving the cnt==1 cycle to present the product.
  always_comb begin
    step_in    = accept ? {{W{1'b0}}, b} : prod;
    step_mcand = accept ? a : mcand;
    step_sum   = {1'b0, step_in[2*W-1:W]}
               + (step_in[0] ? {1'b0, step_mcand} : {(W+1){1'b0}});
    prod_step  = {step_sum, step_in[W-1:1]};
  end

  always_comb begin
    wr_res  = accept && (op != OP_MUL);
    res_nxt = exec_r;
    c_nxt   = exec_c;
    v_nxt   = exec_v;
    if (mul_last) begin
      wr_res  = 1'b1;
      res_nxt = prod_step[W-1:0];
      c_nxt   = |prod_step[2*W-1:W];
      v_nxt   = 1'b0;
    end
    flg_nxt         = '0;
    flg_nxt[FLAG_N] = res_nxt[W-1];
    flg_nxt[FLAG_Z] = (res_nxt == '0);
    flg_nxt[FLAG_C] = c_nxt;
    flg_nxt[FLAG_V] = v_nxt;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (accept && (op == OP_MUL)) begin
      cnt <= CW'(W);
    end else if (state == ST_MUL) begin
      cnt <= cnt - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mcand  <= '0;
      prod   <= '0;
      result <= '0;
      flags  <= '0;
    end else begin
      if (accept) mcand <= a;
      if (accept || ((state == ST_MUL) && !done)) prod <= prod_step;
      if (wr_res) begin
        result <= res_nxt;
        flags  <= flg_nxt;
      end
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq (W=8): directed corner cases, reset abort, and random ops
// compared against an integer-arithmetic reference model.
module tb_alu_seq;

  localparam int W = 8;

  logic         clk   = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [2:0]   op    = '0;
  logic [W-1:0] a     = '0;
  logic [W-1:0] b     = '0;
  logic         busy, done;
  logic [W-1:0] result;
  logic [3:0]   flags;

  int ncomp = 0;
  int nfail = 0;

  alu_seq #(.W(W)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .op     (op),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .result (result),
    .flags  (flags)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    ncomp++;
    assert (got === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: evaluate the op on unbounded integers, then reduce to W bits.
  function automatic void model(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                                output logic [W-1:0] r, output logic [3:0] f);
    int unsigned m  = 32'(1) << W;
    int unsigned ux = 32'(x);
    int unsigned uy = 32'(y);
    int unsigned full;
    int sx = (ux >= m / 2) ? int'(ux) - int'(m) : int'(ux);
    int sy = (uy >= m / 2) ? int'(uy) - int'(m) : int'(uy);
    int sr;
    bit c = 1'b0;
    bit v = 1'b0;
    case (o)
      3'd0: full = ux & uy;
      3'd1: full = ux | uy;
      3'd2: full = ux ^ uy;
      3'd3: full = ~ux;
      3'd4: begin
        full = ux + uy;
        c    = (full >= m);
        sr   = sx + sy;
        v    = (sr > int'(m / 2) - 1) || (sr < -int'(m / 2));
      end
      3'd5: begin
        full = ux + m - uy;
        c    = (ux >= uy);
        sr   = sx - sy;
        v    = (sr > int'(m / 2) - 1) || (sr < -int'(m / 2));
      end
      3'd6: begin
        full = ux * uy;
        c    = (full >= m);
      end
      default: full = ~(ux | uy);
    endcase
    r = W'(full % m);
    f = {r[W-1], (r == '0), c, v};
  endfunction

  // Issue one op, check busy/done every cycle up to the expected latency, then idle/hold.
  // With hammer set, start stays high with ADD requests throughout, including the done cycle.
  task automatic run_op(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                        input bit hammer);
    logic [W-1:0] er;
    logic [3:0]   ef;
    int           lat;
    model(o, x, y, er, ef);
    lat   = (o == 3'b110) ? W : 1;
    op    = o;
    a     = x;
    b     = y;
    start = 1'b1;
    @(posedge clk); #1;
    for (int k = 1; k <= lat; k++) begin
      if (k > 1) begin
        @(posedge clk); #1;
      end
      start = hammer;
      op    = hammer ? 3'b100 : 3'($urandom);
      a     = W'($urandom);
      b     = W'($urandom);
      chk("busy", 16'(busy), 16'd1);
      chk("done", 16'(done), 16'(k == lat));
      if (k == lat) begin
        chk("result", 16'(result), 16'(er));
        chk("flags", 16'(flags), 16'(ef));
      end
    end
    @(posedge clk); #1;
    start = 1'b0;
    chk("idle_busy", 16'(busy), 16'd0);
    chk("idle_done", 16'(done), 16'd0);
    chk("hold_result", 16'(result), 16'(er));
    chk("hold_flags", 16'(flags), 16'(ef));
  endtask

  initial begin
    int seen;

    rst_n = 1'b0;
    start = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    start = 1'b0;
    chk("rst_busy", 16'(busy), 16'd0);
    chk("rst_done", 16'(done), 16'd0);
    chk("rst_result", 16'(result), 16'd0);
    chk("rst_flags", 16'(flags), 16'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_op(3'b100, 8'h7F, 8'h01, 1'b0);
    chk("add_7f_01_res", 16'(result), 16'h80);
    chk("add_7f_01_flg", 16'(flags), 16'b1001);
    run_op(3'b101, 8'h05, 8'h05, 1'b1);
    chk("sub_eq_flg", 16'(flags), 16'b0110);
    run_op(3'b101, 8'h00, 8'h01, 1'b0);
    chk("sub_borrow_res", 16'(result), 16'hFF);
    chk("sub_borrow_flg", 16'(flags), 16'b1000);
    run_op(3'b110, 8'h10, 8'h10, 1'b0);
    chk("mul_ovf_flg", 16'(flags), 16'b0110);
    run_op(3'b011, 8'hA5, 8'h77, 1'b0);
    chk("not_res", 16'(result), 16'h5A);
    run_op(3'b111, 8'hF0, 8'h0F, 1'b0);
    run_op(3'b000, 8'hA5, 8'h3C, 1'b0);
    chk("and_res", 16'(result), 16'h24);
    run_op(3'b001, 8'hA5, 8'h3C, 1'b1);
    chk("or_res", 16'(result), 16'hBD);
    run_op(3'b010, 8'hA5, 8'h3C, 1'b0);
    chk("xor_res", 16'(result), 16'h99);
    run_op(3'b110, 8'h0F, 8'h11, 1'b1);
    chk("mul_ff_res", 16'(result), 16'hFF);
    chk("mul_ff_flg", 16'(flags), 16'b1000);

    // Reset asserted in MUL cycle 4 with a competing start.
    op    = 3'b110;
    a     = 8'h33;
    b     = 8'h55;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    chk("pre_abort_busy", 16'(busy), 16'd1);
    rst_n = 1'b0;
    start = 1'b1;
    op    = 3'b100;
    @(posedge clk); #1;
    rst_n = 1'b1;
    start = 1'b0;
    chk("abort_busy", 16'(busy), 16'd0);
    chk("abort_done", 16'(done), 16'd0);
    chk("abort_result", 16'(result), 16'd0);
    chk("abort_flags", 16'(flags), 16'd0);
    seen = 0;
    repeat (W + 2) begin
      @(posedge clk); #1;
      if (done || busy) seen++;
    end
    chk("abort_no_done", 16'(seen), 16'd0);

    repeat (60) begin
      run_op(3'($urandom), W'($urandom), W'($urandom), 1'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncomp, nfail);
    $finish;
  end

endmodule
